booth_divider: RTL

Sequential signed divider, the inverse datapath of the team's combinational 32×32→64 Booth multiplier. It accepts a 64-bit signed dividend and a 32-bit signed divisor, and returns a 32-bit quotient and a 32-bit remainder with truncating (round-toward-zero) semantics. The core is a radix-2 restoring engine working on magnitudes, producing one quotient bit per cycle. It sits beside the multiplier in the arithmetic unit, behind a start/done handshake.

---
 rtl/arith_pkg.sv | 13 +
 rtl/div_step.sv | 18 +
 rtl/booth_divider.sv | 113 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding, default width
// and an absolute-value helper usable by both the divider and the multiplier.
package arith_pkg;

   localparam int DIV_DW = 32;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

   function automatic logic [2*DIV_DW-1:0] abs_val(input logic [2*DIV_DW-1:0] x);
      return x[2*DIV_DW-1] ? -x : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// already-shifted partial remainder, yielding the next remainder and quotient bit.
module div_step
   import arith_pkg::*;
#(
   parameter int DW = DIV_DW
) (
   input  logic [DW:0]   prem,
   input  logic [DW-1:0] dsr,
   output logic [DW-1:0] rem_nxt,
   output logic          qbit
);

   // The partial remainder stays below 2*dsr, so a kept difference always fits DW bits.
   assign qbit    = (prem >= {1'b0, dsr});
   assign rem_nxt = qbit ? (prem[DW-1:0] - dsr) : prem[DW-1:0];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed 2*DW / DW divider: magnitude restoring engine, one quotient
// bit per cycle, truncating signs applied in a final fixup cycle.
module booth_divider
   import arith_pkg::*;
#(
   parameter int DW = DIV_DW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            busy,
   output logic            done,
   output logic [DW-1:0]   quotient,
   output logic [DW-1:0]   remainder,
   output logic            overflow,
   output logic            div_by_zero
);

   localparam int CW = $clog2(DW);

   div_state_t      state;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   rem_q, quo_q, dsr;
   logic            q_neg, r_neg, ovf_f, dbz_f;

   logic [2*DW-1:0] dvd_abs;
   logic [DW-1:0]   dsr_abs, step_rem;
   logic            step_q, pre_ovf, dsr_zero, post_ovf;

   assign dvd_abs  = dividend[2*DW-1] ? -dividend : dividend;
   assign dsr_abs  = divisor[DW-1] ? -divisor : divisor;
   assign dsr_zero = (divisor == '0);
   // Upper half >= divisor means the unsigned quotient needs more than DW bits.
   assign pre_ovf  = (dvd_abs[2*DW-1:DW] >= dsr_abs);
   // A negative result may reach -2^(DW-1); a positive one only 2^(DW-1)-1.
   assign post_ovf = q_neg ? (quo_q[DW-1] & (|quo_q[DW-2:0])) : quo_q[DW-1];

   div_step #(.DW(DW)) u_step (
      .prem    ({rem_q, quo_q[DW-1]}),
      .dsr     (dsr),
      .rem_nxt (step_rem),
      .qbit    (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         ovf_f       <= 1'b0;
         dbz_f       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rem_q       <= dvd_abs[2*DW-1:DW];
               quo_q       <= dvd_abs[DW-1:0];
               dsr         <= dsr_abs;
               q_neg       <= dividend[2*DW-1] ^ divisor[DW-1];
               r_neg       <= dividend[2*DW-1];
               dbz_f       <= dsr_zero;
               ovf_f       <= pre_ovf;
               overflow    <= 1'b0;
               div_by_zero <= 1'b0;
               busy        <= 1'b1;
               cnt         <= CW'(DW-1);
               state       <= (dsr_zero || pre_ovf) ? FIX : RUN;
            end
            RUN: begin
               rem_q <= step_rem;
               quo_q <= {quo_q[DW-2:0], step_q};
               cnt   <= cnt - CW'(1);
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               done  <= 1'b1;
               state <= DONE;
               if (dbz_f) begin
                  // Register still holds |dividend|; re-signing restores the raw low half.
                  div_by_zero <= 1'b1;
                  quotient    <= '1;
                  remainder   <= r_neg ? -quo_q : quo_q;
               end else if (ovf_f || post_ovf) begin
                  overflow  <= 1'b1;
                  quotient  <= {1'b1, {(DW-1){1'b0}}};
                  remainder <= '0;
               end else begin
                  quotient  <= q_neg ? -quo_q : quo_q;
                  remainder <= r_neg ? -rem_q : rem_q;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
